// File: rtl/alu_defs.sv
// Shared definitions for the ALU execute stage.
// Opcodes, FSM state encodings and datapath defaults.
package alu_defs;

  localparam int WIDTH_DEF = 32;
  localparam int SHAMT_W   = 5;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0001;
  localparam logic [3:0] OP_AND   = 4'b0010;
  localparam logic [3:0] OP_OR    = 4'b0011;
  localparam logic [3:0] OP_XOR   = 4'b0100;
  localparam logic [3:0] OP_SLL   = 4'b0101;
  localparam logic [3:0] OP_SRL   = 4'b0110;
  localparam logic [3:0] OP_SRA   = 4'b0111;
  localparam logic [3:0] OP_SLT   = 4'b1000;
  localparam logic [3:0] OP_SLTU  = 4'b1001;
  localparam logic [3:0] OP_MUL   = 4'b1010;
  localparam logic [3:0] OP_PASSB = 4'b1011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/alu_exec_stage_mul_iter.sv
// Iterative shift-add multiplier, one partial product per edge.
// done is asserted during the cycle whose edge completes the last iteration.
module mul_iter
  import alu_defs::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ITER  = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             done,
  output logic [WIDTH-1:0] product
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam logic [CW-1:0] LAST = CW'(ITER - 1);

  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_nxt;
  logic [CW-1:0]    cnt;
  logic             running;

  assign acc_nxt = acc + (mplier[0] ? mcand : '0);
  assign product = acc_nxt;
  assign done    = running && (cnt == LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mcand   <= '0;
      mplier  <= '0;
      acc     <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      mcand   <= a;
      mplier  <= b;
      acc     <= '0;
      cnt     <= '0;
      running <= 1'b1;
    end else if (running) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (done) begin
        running <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_exec_stage.sv
// ALU execute stage: valid/ready handshake, single-cycle ops
// and an iterative multiplier behind an IDLE/MUL/DONE FSM.
module alu_exec_stage
  import alu_defs::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int MUL_ITER = WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       alu_op,
  input  logic [WIDTH-1:0] in_A,
  input  logic [WIDTH-1:0] in_B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow,
  output logic             busy
);

  state_e state_q;
  state_e state_d;

  logic             accept;
  logic             is_mul;
  logic             mul_start;
  logic             mul_done;
  logic [WIDTH-1:0] mul_prod;

  logic [WIDTH-1:0]   res_c;
  logic               ovf_c;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic [SHAMT_W-1:0] sa;

  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             ovf_q;

  assign accept    = in_valid && in_ready;
  assign is_mul    = (alu_op == OP_MUL);
  assign mul_start = accept && is_mul;

  assign sum  = in_A + in_B;
  assign diff = in_A - in_B;
  assign sa   = in_B[SHAMT_W-1:0];

  always_comb begin
    res_c = '0;
    ovf_c = 1'b0;
    unique case (alu_op)
      OP_ADD: begin
        res_c = sum;
        ovf_c = (in_A[WIDTH-1] == in_B[WIDTH-1]) &&
                (sum[WIDTH-1] != in_A[WIDTH-1]);
      end
      OP_SUB: begin
        res_c = diff;
        ovf_c = (in_A[WIDTH-1] != in_B[WIDTH-1]) &&
                (diff[WIDTH-1] != in_A[WIDTH-1]);
      end
      OP_AND:   res_c = in_A & in_B;
      OP_OR:    res_c = in_A | in_B;
      OP_XOR:   res_c = in_A ^ in_B;
      OP_SLL:   res_c = in_A << sa;
      OP_SRL:   res_c = in_A >> sa;
      OP_SRA:   res_c = $signed(in_A) >>> sa;
      OP_SLT: begin
        res_c[0] = $signed(in_A) < $signed(in_B);
      end
      OP_SLTU: begin
        res_c[0] = in_A < in_B;
      end
      OP_PASSB: res_c = in_B;
      default:  res_c = '0;
    endcase
  end

  mul_iter #(
    .WIDTH (WIDTH),
    .ITER  (MUL_ITER)
  ) u_mul (
    .clk     (clk),
    .reset   (reset),
    .start   (mul_start),
    .a       (in_A),
    .b       (in_B),
    .done    (mul_done),
    .product (mul_prod)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          state_d = is_mul ? S_MUL : S_DONE;
        end else if (state_q == S_DONE && out_ready) begin
          state_d = S_IDLE;
        end
      end
      S_MUL: begin
        if (mul_done) begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state_q)
      S_IDLE: in_ready = 1'b1;
      S_MUL:  busy = 1'b1;
      S_DONE: begin
        out_valid = 1'b1;
        in_ready  = out_ready;
      end
      default: in_ready = 1'b0;
    endcase
  end

  // Result flags are registered so they hold through a stalled DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q <= '0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else if (accept && !is_mul) begin
      result_q <= res_c;
      zero_q   <= (res_c == '0);
      ovf_q    <= ovf_c;
    end else if (mul_done) begin
      result_q <= mul_prod;
      zero_q   <= (mul_prod == '0);
      ovf_q    <= 1'b0;
    end
  end

  assign result   = result_q;
  assign zero     = zero_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Directed bench for alu_exec_stage with hand-computed vectors.
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_alu_exec_stage;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  alu_op;
  logic [31:0] in_A;
  logic [31:0] in_B;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  alu_exec_stage dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .in_A      (in_A),
    .in_B      (in_B),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .overflow  (overflow),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    in_valid = 1'b1;
    alu_op   = op;
    in_A     = a;
    in_B     = b;
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b);
    drive(op, a, b);
    step();
    in_valid = 1'b0;
  endtask

  int n;
  int bad;

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    alu_op    = 4'h0;
    in_A      = '0;
    in_B      = '0;
    out_ready = 1'b1;
    #1 reset = 1'b1;
    #2;
    chk("rst_result", result, 32'h0);
    chk("rst_zero", {31'b0, zero}, 32'h0);
    chk("rst_ovf", {31'b0, overflow}, 32'h0);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_busy", {31'b0, busy}, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
    step();
    reset = 1'b0;

    // ADD signed overflow
    run_op(4'b0000, 32'h7FFF_FFFF, 32'h1);
    chk("add_valid", {31'b0, out_valid}, 32'h1);
    chk("add_result", result, 32'h8000_0000);
    chk("add_ovf", {31'b0, overflow}, 32'h1);
    chk("add_zero", {31'b0, zero}, 32'h0);
    step();

    // SUB then SLT back-to-back
    drive(4'b0001, 32'd5, 32'd5);
    step();
    chk("sub_result", result, 32'h0);
    chk("sub_zero", {31'b0, zero}, 32'h1);
    chk("sub_in_ready", {31'b0, in_ready}, 32'h1);
    drive(4'b1000, 32'hFFFF_FFFF, 32'h1);
    step();
    in_valid = 1'b0;
    chk("slt_valid", {31'b0, out_valid}, 32'h1);
    chk("slt_result", result, 32'h1);
    chk("slt_zero", {31'b0, zero}, 32'h0);
    chk("slt_in_ready", {31'b0, in_ready}, 32'h1);
    step();
    chk("idle_out_valid", {31'b0, out_valid}, 32'h0);

    // MUL 7*6 with operands scrambled after accept
    run_op(4'b1010, 32'd7, 32'd6);
    in_A = 32'hDEAD_BEEF;
    in_B = 32'h1234_5678;
    n = 0;
    bad = 0;
    while (!out_valid && n < 40) begin
      if (busy !== 1'b1 || in_ready !== 1'b0) bad++;
      step();
      n++;
    end
    chk("mul_latency", n, 32);
    chk("mul_busy_cycles", bad, 0);
    chk("mul_result", result, 32'h0000_002A);
    chk("mul_ovf", {31'b0, overflow}, 32'h0);
    chk("mul_busy_done", {31'b0, busy}, 32'h0);
    step();

    // SRA with stalled consumer, new bundle waiting
    out_ready = 1'b0;
    run_op(4'b0111, 32'h8000_0000, 32'h0000_0024);
    drive(4'b0000, 32'd1, 32'd1);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      if (result !== 32'hF800_0000 || in_ready !== 1'b0 ||
          out_valid !== 1'b1) bad++;
      step();
    end
    chk("sra_hold", bad, 0);
    chk("sra_result", result, 32'hF800_0000);
    out_ready = 1'b1;
    #1;
    chk("sra_in_ready", {31'b0, in_ready}, 32'h1);
    step();
    in_valid = 1'b0;
    chk("stall_next_add", result, 32'd2);
    step();

    // Reset mid-multiply
    run_op(4'b1010, 32'h0000_FFFF, 32'h0000_FFFF);
    for (int i = 0; i < 10; i++) step();
    chk("pre_rst_busy", {31'b0, busy}, 32'h1);
    reset = 1'b1;
    #1;
    chk("mrst_result", result, 32'h0);
    chk("mrst_busy", {31'b0, busy}, 32'h0);
    chk("mrst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("mrst_in_ready", {31'b0, in_ready}, 32'h1);
    step();
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
      step();
    end
    chk("mrst_no_stale", bad, 0);
    run_op(4'b0000, 32'd2, 32'd3);
    chk("post_add_valid", {31'b0, out_valid}, 32'h1);
    chk("post_add_result", result, 32'd5);
    step();

    // Misc ops
    run_op(4'b0001, 32'h8000_0000, 32'h1);
    chk("sub_ovf_result", result, 32'h7FFF_FFFF);
    chk("sub_ovf", {31'b0, overflow}, 32'h1);
    run_op(4'b1001, 32'hFFFF_FFFF, 32'h1);
    chk("sltu_result", result, 32'h0);
    chk("sltu_zero", {31'b0, zero}, 32'h1);
    run_op(4'b0101, 32'h0000_0003, 32'h0000_0021);
    chk("sll_result", result, 32'h0000_0006);
    run_op(4'b0110, 32'h8000_0000, 32'h0000_001F);
    chk("srl_result", result, 32'h0000_0001);
    run_op(4'b0100, 32'hFF00_FF00, 32'h0F0F_0F0F);
    chk("xor_result", result, 32'hF00F_F00F);
    run_op(4'b1011, 32'h1111_1111, 32'hCAFE_0001);
    chk("passb_result", result, 32'hCAFE_0001);
    run_op(4'b1111, 32'hFFFF_FFFF, 32'h1);
    chk("op15_result", result, 32'h0);
    chk("op15_zero", {31'b0, zero}, 32'h1);
    chk("op15_ovf", {31'b0, overflow}, 32'h0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
